// File: rtl/cfg_chain_loader.sv
// Serial configuration-chain loader: accepts CHAIN_LEN bitstream bits over valid/ready,
// shifts them into the fabric config chain, then checks the tail returns the first bit.
module cfg_chain_loader #(
    parameter int CHAIN_LEN     = 64,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(CHAIN_LEN + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic bit_valid,
    input  logic bit_data,
    output logic bit_ready,
    output logic ccff_head,
    output logic prog_en,
    input  logic ccff_tail,
    output logic busy,
    output logic done,
    output logic error
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             first_bit_q, first_bit_d;
    logic             head_q, head_d;
    logic             prog_q, prog_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             transfer;

    assign bit_ready = (state_q == ST_LOAD);
    assign transfer  = bit_valid & bit_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        settle_d    = settle_q;
        first_bit_d = first_bit_q;
        head_d      = head_q;
        prog_d      = 1'b0;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    cnt_d    = '0;
                    settle_d = '0;
                end
            end
            ST_LOAD: begin
                // abort takes priority over a coincident transfer
                if (abort) begin
                    state_d  = ST_IDLE;
                    error_d  = 1'b1;
                    done_d   = 1'b0;
                    cnt_d    = '0;
                    settle_d = '0;
                end else if (transfer) begin
                    head_d = bit_data;
                    prog_d = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == '0) begin
                        first_bit_d = bit_data;
                    end
                    if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    error_d  = 1'b1;
                    done_d   = 1'b0;
                    cnt_d    = '0;
                    settle_d = '0;
                end else if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    // last settle cycle: tail must now present the first loaded bit
                    error_d  = (ccff_tail != first_bit_q);
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            settle_q    <= '0;
            first_bit_q <= 1'b0;
            head_q      <= 1'b0;
            prog_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            first_bit_q <= first_bit_d;
            head_q      <= head_d;
            prog_q      <= prog_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign ccff_head = head_q;
    assign prog_en   = prog_q;
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_SETTLE);
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader with a behavioural chain model on ccff_tail.
module tb_cfg_chain_loader;

    localparam int CL = 8;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_data = 1'b0;
    logic ccff_tail;
    logic bit_ready, ccff_head, prog_en, busy, done, error;

    logic [CL-1:0] chain = '0;
    logic          tie0 = 1'b0;
    logic          pulses[$];
    int            total = 0;
    int            passed = 0;

    cfg_chain_loader #(.CHAIN_LEN(CL), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
        .ccff_head(ccff_head), .prog_en(prog_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Chain model: shift register clocked by prog_en, tail is the oldest bit.
    always @(posedge clk) if (prog_en) chain <= {chain[CL-2:0], ccff_head};
    assign ccff_tail = tie0 ? 1'b0 : chain[CL-1];

    always @(negedge clk) if (prog_en) pulses.push_back(ccff_head);

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [CL-1:0] pulse_word();
        logic [CL-1:0] w = '0;
        for (int i = 0; i < CL && i < pulses.size(); i++) w[CL-1-i] = pulses[i];
        return w;
    endfunction

    // Starts a load and offers seq MSB-first; records done/busy/ready for cycles T+1..T+SC+1.
    task automatic run_load(input logic [CL-1:0] seq, input int gap_pct, input bit start_mid,
                            output bit to, output logic [SC:0] rdy_h, output logic [SC:0] dn_h,
                            output logic [SC:0] bsy_h);
        int idx = 0;
        int guard = 0;
        bit xfer;
        pulses.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (idx < CL && guard < 400) begin
            bit_valid = ($urandom_range(99) >= gap_pct);
            bit_data  = seq[CL-1-idx];
            start     = start_mid && (idx == 3);
            xfer      = bit_valid && bit_ready;
            tick();
            if (xfer) idx++;
            guard++;
        end
        start = 1'b0;
        to = (idx < CL);
        for (int k = 0; k <= SC; k++) begin
            bit_valid = 1'b1;
            bit_data  = 1'($urandom_range(1));
            rdy_h[k]  = bit_ready;
            dn_h[k]   = done;
            bsy_h[k]  = busy;
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (prog_en !== 1'b0) $display("FAIL rst_prog_en: got %b want 0", prog_en); else passed++;
        total++; if (bit_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bit_ready); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
        total++; if (error !== 1'b0) $display("FAIL rst_error: got %b want 0", error); else passed++;
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            bit_data  = 1'($urandom_range(1));
            tick();
        end
        bit_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else passed++;
        total++; if (prog_en !== 1'b0) $display("FAIL arst_prog_en: got %b want 0", prog_en); else passed++;
        total++; if (bit_ready !== 1'b0) $display("FAIL arst_ready: got %b want 0", bit_ready); else passed++;
        total++; if (done !== 1'b0) $display("FAIL arst_done: got %b want 0", done); else passed++;
        total++; if (error !== 1'b0) $display("FAIL arst_error: got %b want 0", error); else passed++;
        tick();
        rst_n = 1'b1;
        pulses.delete();
        bit_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bit_valid = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
        total++; if (pulses.size() !== 0) $display("FAIL idle_pulses: got %0d want 0", pulses.size()); else passed++;
    endtask

    task automatic test_nominal();
        logic [CL-1:0] seq = 8'b10110010;
        logic [SC:0] rdy_h, dn_h, bsy_h, dn_exp, bsy_exp;
        bit to;
        dn_exp = '0; dn_exp[SC] = 1'b1;
        bsy_exp = ~dn_exp;
        tie0 = 1'b0;
        run_load(seq, 0, 1'b0, to, rdy_h, dn_h, bsy_h);
        total++; if (to !== 1'b0) $display("FAIL nom_timeout: got %b want 0", to); else passed++;
        total++; if (pulses.size() !== CL) $display("FAIL nom_count: got %0d want %0d", pulses.size(), CL); else passed++;
        total++; if (pulse_word() !== seq) $display("FAIL nom_order: got %b want %b", pulse_word(), seq); else passed++;
        total++; if (rdy_h !== '0) $display("FAIL nom_ready_after: got %b want 0", rdy_h); else passed++;
        total++; if (dn_h !== dn_exp) $display("FAIL nom_done_timing: got %b want %b", dn_h, dn_exp); else passed++;
        total++; if (bsy_h !== bsy_exp) $display("FAIL nom_busy_timing: got %b want %b", bsy_h, bsy_exp); else passed++;
        total++; if (error !== 1'b0) $display("FAIL nom_error: got %b want 0", error); else passed++;
        total++; if (chain !== seq) $display("FAIL nom_chain: got %b want %b", chain, seq); else passed++;
    endtask

    task automatic test_backpressure();
        logic [CL-1:0] seq = 8'b10110010;
        logic [SC:0] rdy_h, dn_h, bsy_h;
        bit to;
        for (int r = 0; r < 3; r++) begin
            run_load(seq, 45, 1'b0, to, rdy_h, dn_h, bsy_h);
            total++; if (to !== 1'b0) $display("FAIL bp_timeout: got %b want 0", to); else passed++;
            total++; if (pulses.size() !== CL) $display("FAIL bp_count: got %0d want %0d", pulses.size(), CL); else passed++;
            total++; if (pulse_word() !== seq) $display("FAIL bp_order: got %b want %b", pulse_word(), seq); else passed++;
            total++; if (rdy_h !== '0) $display("FAIL bp_no_ninth: got %b want 0", rdy_h); else passed++;
            total++; if (done !== 1'b1 || error !== 1'b0)
                $display("FAIL bp_status: got done=%b err=%b want done=1 err=0", done, error); else passed++;
            seq = 8'($urandom());
        end
    endtask

    task automatic test_tail_fault();
        logic [CL-1:0] seq;
        logic [SC:0] rdy_h, dn_h, bsy_h;
        bit to;
        tie0 = 1'b1;
        for (int f = 1; f >= 0; f--) begin
            seq = 8'($urandom());
            seq[CL-1] = 1'(f);
            run_load(seq, 20, 1'b0, to, rdy_h, dn_h, bsy_h);
            total++; if (done !== 1'b1) $display("FAIL tail_done first=%0d: got %b want 1", f, done); else passed++;
            total++; if (error !== 1'(f)) $display("FAIL tail_error first=%0d: got %b want %0d", f, error, f); else passed++;
        end
        tie0 = 1'b0;
    endtask

    task automatic test_abort();
        logic [CL-1:0] seq;
        logic [2:0] sent;
        logic [SC:0] rdy_h, dn_h, bsy_h;
        bit to;
        for (int c = 0; c < 2; c++) begin
            pulses.delete();
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                bit_valid = 1'b1;
                bit_data  = 1'($urandom_range(1));
                sent[2-i] = bit_data;
                tick();
            end
            // c=0: abort alone; c=1: abort coincides with the 4th transfer
            bit_valid = 1'(c);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            bit_valid = 1'b0;
            total++; if (busy !== 1'b0) $display("FAIL abort%0d_busy: got %b want 0", c, busy); else passed++;
            total++; if (done !== 1'b0) $display("FAIL abort%0d_done: got %b want 0", c, done); else passed++;
            total++; if (error !== 1'b1) $display("FAIL abort%0d_error: got %b want 1", c, error); else passed++;
            total++; if (prog_en !== 1'b0) $display("FAIL abort%0d_prog_en: got %b want 0", c, prog_en); else passed++;
            bit_valid = 1'b1;
            for (int i = 0; i < 3; i++) tick();
            bit_valid = 1'b0;
            total++; if (pulses.size() !== 3) $display("FAIL abort%0d_count: got %0d want 3", c, pulses.size()); else passed++;
            total++; if (pulse_word() !== {sent, 5'b0}) $display("FAIL abort%0d_order: got %b want %b", c, pulse_word(), {sent, 5'b0}); else passed++;
        end
        seq = 8'($urandom());
        run_load(seq, 20, 1'b0, to, rdy_h, dn_h, bsy_h);
        total++; if (done !== 1'b1 || error !== 1'b0)
            $display("FAIL abort_recover: got done=%b err=%b want done=1 err=0", done, error); else passed++;
        total++; if (chain !== seq) $display("FAIL abort_recover_chain: got %b want %b", chain, seq); else passed++;
    endtask

    task automatic test_ignored();
        logic [CL-1:0] seq;
        logic [SC:0] rdy_h, dn_h, bsy_h;
        bit to;
        pulses.delete();
        bit_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bit_valid = 1'b0;
        total++; if (pulses.size() !== 0) $display("FAIL done_valid_pulses: got %0d want 0", pulses.size()); else passed++;
        total++; if (done !== 1'b1) $display("FAIL done_held: got %b want 1", done); else passed++;
        seq = 8'($urandom());
        run_load(seq, 0, 1'b1, to, rdy_h, dn_h, bsy_h);
        total++; if (pulses.size() !== CL) $display("FAIL midstart_count: got %0d want %0d", pulses.size(), CL); else passed++;
        total++; if (pulse_word() !== seq) $display("FAIL midstart_order: got %b want %b", pulse_word(), seq); else passed++;
        tie0 = 1'b1;
        seq = 8'($urandom());
        seq[CL-1] = 1'b1;
        run_load(seq, 0, 1'b0, to, rdy_h, dn_h, bsy_h);
        tie0 = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (done !== 1'b0) $display("FAIL restart_done: got %b want 0", done); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL restart_busy: got %b want 1", busy); else passed++;
        total++; if (error !== 1'b0) $display("FAIL restart_error: got %b want 0", error); else passed++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_tail_fault();
        test_abort();
        test_ignored();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule
